ctl_input_conditioner: RTL and testbench
========================================

Name: ctl_input_conditioner

Overview:
- Upstream front end of the count-to-15 controller/counter datapath.
- Takes two raw, asynchronous, bouncy inputs (start button, count-enable level) and the global reset.
- Produces the controller's inputs:
  - S: clean one-cycle start pulse.
  - X: clean count-enable level.
  - set: power-up initialisation strobe that forces the controller into its idle state T0.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a synchronised input is accepted (legal 1..15).
- INIT_CYCLES, 2, cycles that set stays high after reset deasserts (legal 1..15).
- CNT_W, 4, width of the debounce and init counters; must hold max(DEBOUNCE_CYCLES, INIT_CYCLES).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start_raw  in  1  asynchronous, bouncy start request.
- x_raw  in  1  asynchronous, bouncy count-enable level.
- S  out  1  one-cycle start pulse to the controller.
- X  out  1  debounced count-enable level to controller and counter enable logic.
- set  out  1  init strobe to the controller's T0 flop.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values (the edge at which reset=1 is sampled):
  - All synchroniser flops 0, all stable values 0, all counters 0.
  - S=0, X=0, set=1.
- Synchroniser: each raw input passes through 2 flops (sync1, sync2). No logic between them.
- Debounce, per channel:
  - Each edge, if sync2 == stable: counter cleared to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, stable takes sync2 and the counter clears, on the same edge.
  - Any single-cycle return of sync2 to stable restarts the count from 0.
- Latency: a raw transition held steady and first sampled at edge k changes stable at edge k+1+DEBOUNCE_CYCLES. With the default this is 6 edges after the raw change is first seen.
- X = stable value of the x channel, driven directly from a flop.
- S, edge detect on the start channel:
  - start_prev flop holds the previous start stable value.
  - S = start_stable & ~start_prev & ~set.
  - S is high for exactly one cycle per accepted rising edge, regardless of how long start_raw is held.
  - Falling edges produce nothing.
- set sequencer:
  - While reset=1: set=1 and init_cnt=0.
  - After reset deasserts, set stays 1 for INIT_CYCLES more edges, then goes to 0 and stays 0 until the next reset.
- Lockout: a start rising edge accepted while set=1 is discarded, not queued. start_prev still updates, so no late S appears after set falls.
- Simultaneous events: start and x channels are fully independent; both may update on the same edge.
- Reset mid-operation, asserted on any edge:
  - Clears all channel state, forces S=0 and X=0, restarts the set sequence.
  - In-progress debounce counts are lost.
- No glitch, bounce or pulse shorter than DEBOUNCE_CYCLES consecutive cycles at sync2 may reach S or X.

Decomposition:
- Shared package ctl_pkg:
  - DEBOUNCE_CYCLES_DEF = 4, INIT_CYCLES_DEF = 2.
  - CNT_W_DEF = 4.
  - Enum name for the set sequencer states INIT / RUN.
- Sub-module debounce_channel:
  - Contents: 2-flop synchroniser, debounce counter, stable flop.
  - Ports: clock, reset, raw, stable. Parameterised by DEBOUNCE_CYCLES and CNT_W.
  - Instantiated twice (start, x).
- Edge detect, lockout and set sequencer live in the top level.

Test Plan:
- Reset held 3 cycles, then released:
  - S=0, X=0 throughout.
  - set=1 during reset and for 2 edges after release, then 0 permanently.
- x_raw 0→1 held steady from after reset sequence: X rises exactly 6 edges after x_raw is first sampled. x_raw 1→0 held: X falls 6 edges later.
- Bounce on x_raw (1 for 2 cycles, 0 for 1, 1 for 3, 0 after): X stays 0 throughout; no count ever reaches 4.
- start_raw rises and is held 20 cycles after set=0: S high for exactly 1 cycle, 6 edges after first sample. No further S while held or on release.
- start_raw raised 1 cycle after reset release, so debounce completes while set=1: no S ever produced for that press. A later clean press produces exactly one S.
- Reset pulsed mid-debounce (x_raw accepted 2 of 4 cycles):
  - Counter, X and S clear; set re-asserts for the reset cycle plus 2.
  - After release, the still-high x_raw needs a full 6-edge latency before X=1.

Source files
------------

// File: rtl/ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctl_pkg
// Description : Shared defaults and types for the count-to-15 controller
//               input conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package ctl_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int INIT_CYCLES_DEF     = 2;
    localparam int CNT_W_DEF           = 4;

    // Power-up sequencer: INIT holds the controller's set strobe high, RUN releases it.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } set_state_e;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : Two-flop synchroniser followed by a consecutive-cycle
//               debouncer. stable only follows the synchronised input after
//               it has differed from stable for DEBOUNCE_CYCLES edges in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    // Count value on the edge that completes the run; the update happens on that same edge.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;

    // Synchronise the raw input, then accept it only after an unbroken run of disagreement.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/ctl_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : ctl_input_conditioner
// Description : Front end of the count-to-15 controller. Debounces the start
//               button and count-enable level, turns accepted start presses
//               into one-cycle S pulses and produces the power-up set strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ctl_input_conditioner
    import ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int INIT_CYCLES     = INIT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start_raw,
    input  logic x_raw,
    output logic S,
    output logic X,
    output logic set
);

    // set stays high until INIT_CYCLES reset-free edges have passed; the next one releases it.
    localparam logic [CNT_W-1:0] C_INIT_LAST = CNT_W'(INIT_CYCLES);

    logic             w_start_stable;
    logic             w_x_stable;
    logic             r_start_prev;
    set_state_e       r_state;
    set_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_init_cnt;
    logic [CNT_W-1:0] w_init_cnt_nxt;
    logic             w_set;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_start_chan (
        .clock  (clock),
        .reset  (reset),
        .raw    (start_raw),
        .stable (w_start_stable)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_x_chan (
        .clock  (clock),
        .reset  (reset),
        .raw    (x_raw),
        .stable (w_x_stable)
    );

    // Set sequencer state and init counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Set sequencer next state: count out the init window, then park in RUN.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_set          = 1'b0;
        case (r_state)
            INIT: begin
                w_set = 1'b1;
                if (r_init_cnt == C_INIT_LAST) begin
                    w_state_nxt    = RUN;
                    w_init_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            RUN: begin
                w_set = 1'b0;
            end
            default: begin
                w_state_nxt    = INIT;
                w_init_cnt_nxt = '0;
                w_set          = 1'b1;
            end
        endcase
    end

    // Previous start level; it tracks even during lockout so a masked press never fires late.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_start_prev <= 1'b0;
        end else begin
            r_start_prev <= w_start_stable;
        end
    end

    assign S   = w_start_stable & ~r_start_prev & ~w_set;
    assign X   = w_x_stable;
    assign set = w_set;

endmodule
`default_nettype wire

// File: tb/tb_ctl_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctl_input_conditioner
// Description : Scoreboard bench. u_dut uses default parameters; u_dut_lk uses
//               a long init window so a start press completes while set=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctl_input_conditioner;

    typedef struct packed {
        logic s;
        logic x;
        logic set;
        logic s2;
        logic x2;
        logic set2;
    } exp_t;

    logic clock;
    logic reset;
    logic start_raw;
    logic x_raw;
    logic S, X, set;
    logic S_lk, X_lk, set_lk;

    exp_t q[$];
    int   n_checks;
    int   n_pass;
    int   n_step;

    ctl_input_conditioner u_dut (
        .clock     (clock),
        .reset     (reset),
        .start_raw (start_raw),
        .x_raw     (x_raw),
        .S         (S),
        .X         (X),
        .set       (set)
    );

    ctl_input_conditioner #(
        .INIT_CYCLES (8)
    ) u_dut_lk (
        .clock     (clock),
        .reset     (reset),
        .start_raw (start_raw),
        .x_raw     (x_raw),
        .S         (S_lk),
        .X         (X_lk),
        .set       (set_lk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive n cycles of inputs and queue the outputs expected after each edge.
    task automatic run(input int n, input logic rst, input logic st, input logic xr,
                       input logic e_s, input logic e_x, input logic e_set,
                       input logic e_s2, input logic e_set2);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset     = rst;
            start_raw = st;
            x_raw     = xr;
            e.s    = e_s;
            e.x    = e_x;
            e.set  = e_set;
            e.s2   = e_s2;
            e.x2   = e_x;
            e.set2 = e_set2;
            q.push_back(e);
        end
    endtask

    // Monitor: just after each rising edge, compare outputs against the oldest queued entry.
    initial begin
        exp_t e;
        exp_t a;
        n_step = 0;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{s: S, x: X, set: set, s2: S_lk, x2: X_lk, set2: set_lk};
                n_step++;
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs step %0d: got {S,X,set,S_lk,X_lk,set_lk}=%b expected %b",
                             n_step, a, e);
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start_raw = 1'b0;
        x_raw     = 1'b0;

        // Reset 3 cycles, release; set=1 for 2 edges (8 on u_dut_lk).
        run(3, 1, 0, 0, 0, 0, 1, 0, 1);
        run(2, 0, 0, 0, 0, 0, 1, 0, 1);
        run(6, 0, 0, 0, 0, 0, 0, 0, 1);
        run(2, 0, 0, 0, 0, 0, 0, 0, 0);

        // x rises: X=1 on the 6th edge that samples it; falls likewise.
        run(5, 0, 0, 1, 0, 0, 0, 0, 0);
        run(3, 0, 0, 1, 0, 1, 0, 0, 0);
        run(5, 0, 0, 0, 0, 1, 0, 0, 0);
        run(3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Bounce 1,1,0,1,1,1,0...: longest run is 3, X never moves.
        run(2, 0, 0, 1, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0, 0, 0, 0);
        run(3, 0, 0, 1, 0, 0, 0, 0, 0);
        run(8, 0, 0, 0, 0, 0, 0, 0, 0);

        // Start held 20 cycles: one S on the 6th edge, nothing on hold or release.
        run(5,  0, 1, 0, 0, 0, 0, 0, 0);
        run(1,  0, 1, 0, 1, 0, 0, 1, 0);
        run(14, 0, 1, 0, 0, 0, 0, 0, 0);
        run(10, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset 1 cycle, start raised right after: u_dut_lk accepts it while set=1 -> no S.
        run(1, 1, 0, 0, 0, 0, 1, 0, 1);
        run(2, 0, 1, 0, 0, 0, 1, 0, 1);
        run(3, 0, 1, 0, 0, 0, 0, 0, 1);
        run(1, 0, 1, 0, 1, 0, 0, 0, 1);
        run(2, 0, 1, 0, 0, 0, 0, 0, 1);
        run(4, 0, 1, 0, 0, 0, 0, 0, 0);
        run(8, 0, 0, 0, 0, 0, 0, 0, 0);
        // Later clean press: exactly one S on both instances.
        run(5, 0, 1, 0, 0, 0, 0, 0, 0);
        run(1, 0, 1, 0, 1, 0, 0, 1, 0);
        run(2, 0, 1, 0, 0, 0, 0, 0, 0);
        run(8, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-debounce of x (count at 2): full latency restarts after release.
        run(4, 0, 0, 1, 0, 0, 0, 0, 0);
        run(1, 1, 0, 1, 0, 0, 1, 0, 1);
        run(2, 0, 0, 1, 0, 0, 1, 0, 1);
        run(3, 0, 0, 1, 0, 0, 0, 0, 1);
        run(3, 0, 0, 1, 0, 1, 0, 0, 1);
        run(3, 0, 0, 1, 0, 1, 0, 0, 0);
        run(5, 0, 0, 0, 0, 1, 0, 0, 0);
        run(2, 0, 0, 0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        repeat (2) @(posedge clock);
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d entries left required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
